win_scan_ctrl: RTL

- Frame sequencer for the 3x3 window memory and its processing pipeline.
- On a start pulse it raster-scans every window position of a zero-padded (IMG_W+2)-wide frame and drives the read strobe and base address.
- It tracks datapath latency so results are written back with strobe and address in raster order, then signals completion.
- It sits between the top-level control and the window memory / filter datapath; one controller exists per parallel memory bank.

---
 rtl/win_scan_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/win_scan_ctrl.sv
// Frame sequencer: raster-scans 3x3 window positions of a zero-padded frame and
// writes results back after PIPE_LAT unheld cycles. Optional macro: OVERRUN_CHK_EN.
module win_scan_ctrl #(
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 32,
  parameter int ADDR_W   = 15,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_base,
  output logic [8:0]        win_col,
  output logic [7:0]        win_row,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [8:0]        LAST_COL = 9'(IMG_W - 1);
  localparam logic [7:0]        LAST_ROW = 8'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] LAST_WR  = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] WRAP_A   = ADDR_W'(3);

  state_t              state_reg;
  logic [PIPE_LAT-1:0] valid_reg;
  logic [PIPE_LAT:0]   valid_next;
  logic [ADDR_W-1:0]   rd_base_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [8:0]          col_reg;
  logic [7:0]          row_reg;
  logic                busy_reg;
  logic                done_reg;

  assign rd_en      = (state_reg == READ) && !hold;
  assign wr_en      = valid_reg[PIPE_LAT-1] && !hold;
  assign valid_next = {valid_reg, rd_en};

  assign rd_base = rd_base_reg;
  assign wr_addr = wr_addr_reg;
  assign win_col = col_reg;
  assign win_row = row_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      valid_reg   <= '0;
      rd_base_reg <= '0;
      wr_addr_reg <= '0;
      col_reg     <= '0;
      row_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (!hold) valid_reg <= valid_next[PIPE_LAT-1:0];
      if (wr_en) wr_addr_reg <= wr_addr_reg + ONE_A;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= READ;
            busy_reg    <= 1'b1;
            rd_base_reg <= '0;
            wr_addr_reg <= '0;
            col_reg     <= '0;
            row_reg     <= '0;
          end
        end
        READ: begin
          if (!hold) begin
            if (col_reg == LAST_COL) begin
              if (row_reg == LAST_ROW) begin
                state_reg <= DRAIN;
              end else begin
                // step over the right pad of this row and the left pad of the next
                col_reg     <= '0;
                row_reg     <= row_reg + 8'd1;
                rd_base_reg <= rd_base_reg + WRAP_A;
              end
            end else begin
              col_reg     <= col_reg + 9'd1;
              rd_base_reg <= rd_base_reg + ONE_A;
            end
          end
        end
        DRAIN: begin
          if (wr_en && (wr_addr_reg == LAST_WR)) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef OVERRUN_CHK_EN
  logic overrun_reg;

  // an accepted start clears the flag; any start while not IDLE sets it
  always_ff @(posedge clk) begin
    if (!rst_n) overrun_reg <= 1'b0;
    else if (start) overrun_reg <= (state_reg != IDLE);
  end

  assign overrun = overrun_reg;
`else
  assign overrun = 1'b0;
`endif

endmodule
